// File: rtl/sha256_compress_iter.sv
// Iterative SHA-256 compression engine: ROUNDS_PER_CYCLE rounds per clock, on-the-fly schedule.
// Optional macro SHA256_CHAIN_EN adds first_blk_i so multi-block messages can chain digests.
module sha256_compress_iter #(
    parameter int unsigned BIT_W            = 32,
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned NUM_ROUNDS       = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [16*BIT_W-1:0]  block_in_i,
`ifdef SHA256_CHAIN_EN
    input  logic                 first_blk_i,
`endif
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [8*BIT_W-1:0]   digest_out_o
);

    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

    localparam int unsigned RndW = $clog2(NUM_ROUNDS + 1);

    if (BIT_W != 32) begin : g_bad_bit_w
        $error("sha256_compress_iter: BIT_W must be 32");
    end
    if (!(ROUNDS_PER_CYCLE inside {1, 2, 4, 8})) begin : g_bad_rpc
        $error("sha256_compress_iter: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end
    if (NUM_ROUNDS == 0 || NUM_ROUNDS > 64 || (NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_nr
        $error("sha256_compress_iter: NUM_ROUNDS must be 1..64 and a multiple of ROUNDS_PER_CYCLE");
    end

    localparam word_t IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    state_e          state_q, state_d;
    word_t           work_q   [8];
    word_t           work_d   [8];
    word_t           work_nxt [8];
    word_t           w_q      [16];
    word_t           w_d      [16];
    word_t           w_nxt    [16];
    word_t           chain_q  [8];
    word_t           chain_d  [8];
    word_t           digest_q [8];
    word_t           digest_d [8];
    logic [RndW-1:0] rnd_q, rnd_d;
    logic            out_valid_q, out_valid_d;

    // R chained rounds; w_nxt[0] is always the word consumed by the next round.
    always_comb begin : p_rounds
        word_t      t1;
        word_t      t2;
        word_t      w_new;
        logic [5:0] k_idx;
        work_nxt = work_q;
        w_nxt    = w_q;
        t1       = '0;
        t2       = '0;
        w_new    = '0;
        k_idx    = '0;
        for (int unsigned j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            k_idx = 6'(rnd_q) + 6'(j);
            t1 = work_nxt[7] + bsig1(work_nxt[4]) + ch(work_nxt[4], work_nxt[5], work_nxt[6])
               + K[k_idx] + w_nxt[0];
            t2 = bsig0(work_nxt[0]) + maj(work_nxt[0], work_nxt[1], work_nxt[2]);
            w_new = ssig1(w_nxt[14]) + w_nxt[9] + ssig0(w_nxt[1]) + w_nxt[0];
            for (int i = 7; i > 0; i--) begin
                work_nxt[i] = work_nxt[i-1];
            end
            work_nxt[4] = work_nxt[4] + t1;
            work_nxt[0] = t1 + t2;
            for (int i = 0; i < 15; i++) begin
                w_nxt[i] = w_nxt[i+1];
            end
            w_nxt[15] = w_new;
        end
    end

    always_comb begin : p_fsm
        state_d     = state_q;
        work_d      = work_q;
        w_d         = w_q;
        rnd_d       = rnd_q;
        chain_d     = chain_q;
        digest_d    = digest_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
`ifdef SHA256_CHAIN_EN
                    if (first_blk_i) begin
                        chain_d = IV;
                        work_d  = IV;
                    end else begin
                        work_d  = chain_q;
                    end
`else
                    chain_d = IV;
                    work_d  = IV;
`endif
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = block_in_i[(15-i)*32 +: 32];
                    end
                    rnd_d   = '0;
                    state_d = StRound;
                end
            end
            StRound: begin
                work_d = work_nxt;
                w_d    = w_nxt;
                rnd_d  = rnd_q + RndW'(ROUNDS_PER_CYCLE);
                if (rnd_d == RndW'(NUM_ROUNDS)) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                for (int i = 0; i < 8; i++) begin
                    chain_d[i]  = chain_q[i] + work_q[i];
                    digest_d[i] = chain_q[i] + work_q[i];
                end
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            work_q      <= '{default: '0};
            w_q         <= '{default: '0};
            chain_q     <= IV;
            digest_q    <= '{default: '0};
            rnd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            w_q         <= w_d;
            chain_q     <= chain_d;
            digest_q    <= digest_d;
            rnd_q       <= rnd_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = out_valid_q;

    always_comb begin
        digest_out_o = '0;
        for (int i = 0; i < 8; i++) begin
            digest_out_o[(7-i)*32 +: 32] = digest_q[i];
        end
    end

endmodule

// File: tb/tb_sha256_compress_iter.sv
// Directed bench for sha256_compress_iter: one R=1 and one R=4 instance on a shared clock/reset.
// The two-block chaining steps run only when SHA256_CHAIN_EN is defined.
module tb_sha256_compress_iter;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [255:0] DIG_ABC   =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
`ifdef SHA256_CHAIN_EN
    localparam logic [511:0] BLK_TWO_1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO_2 = {{14{32'h0}}, 32'h00000000, 32'h000001c0};
    localparam logic [255:0] DIG_TWO   =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    int           cyc = 0;
    int           n_asserts = 0;
    int           n_fail = 0;

    logic         v1, rdy1, ov1, ordy1;
    logic [511:0] blk1;
    logic [255:0] dig1;
    logic         v4, rdy4, ov4, ordy4;
    logic [511:0] blk4;
    logic [255:0] dig4;
`ifdef SHA256_CHAIN_EN
    logic         fb1, fb4;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha256_compress_iter #(.ROUNDS_PER_CYCLE(1)) u_r1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (v1),
        .in_ready_o   (rdy1),
        .block_in_i   (blk1),
`ifdef SHA256_CHAIN_EN
        .first_blk_i  (fb1),
`endif
        .out_valid_o  (ov1),
        .out_ready_i  (ordy1),
        .digest_out_o (dig1)
    );

    sha256_compress_iter #(.ROUNDS_PER_CYCLE(4)) u_r4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (v4),
        .in_ready_o   (rdy4),
        .block_in_i   (blk4),
`ifdef SHA256_CHAIN_EN
        .first_blk_i  (fb4),
`endif
        .out_valid_o  (ov4),
        .out_ready_i  (ordy4),
        .digest_out_o (dig4)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; callers always sit 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a block to the selected instance, wait for out_valid; records edge numbers.
    task automatic run(input bit use_r4, input logic [511:0] blk,
                       output int acc, output int ov_at, output logic [255:0] dig);
        logic pre;
        acc   = -1;
        ov_at = -1;
        if (use_r4) begin v4 = 1'b1; blk4 = blk; end
        else        begin v1 = 1'b1; blk1 = blk; end
        for (int i = 0; i < 20 && acc < 0; i++) begin
            pre = use_r4 ? rdy4 : rdy1;
            step();
            if (pre) acc = cyc;
        end
        if (use_r4) v4 = 1'b0;
        else        v1 = 1'b0;
        for (int i = 0; i < 200 && acc >= 0 && ov_at < 0; i++) begin
            step();
            if (use_r4 ? ov4 : ov1) ov_at = cyc;
        end
        dig = use_r4 ? dig4 : dig1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int           acc, ov_at, hs, pre_i;
        int           accs [3];
        int           n_acc, n_dig;
        logic [255:0] dig, held;
        logic [255:0] digs [3];
        logic         pre;

        v1 = 1'b0; blk1 = '0; ordy1 = 1'b1;
        v4 = 1'b0; blk4 = '0; ordy4 = 1'b1;
`ifdef SHA256_CHAIN_EN
        fb1 = 1'b1; fb4 = 1'b1;
`endif
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("reset_in_ready", 256'(rdy1), 256'(1));
        chk("reset_out_valid", 256'(ov1), 256'(0));
        chk("reset_digest", dig1, '0);

        // "abc" with out_ready high
        run(1'b0, BLK_ABC, acc, ov_at, dig);
        chk("abc_latency", 256'(ov_at - acc), 256'(65));
        chk("abc_digest", dig, DIG_ABC);
        chk("abc_in_ready_in_done", 256'(rdy1), 256'(0));
        step();
        chk("abc_out_valid_cleared", 256'(ov1), 256'(0));
        chk("abc_in_ready_back", 256'(rdy1), 256'(1));
        chk("abc_digest_held", dig1, DIG_ABC);

        // Back-pressure: 20 cycles with out_ready low and a competing block offered
        ordy1 = 1'b0;
        run(1'b0, BLK_ABC, acc, ov_at, dig);
        held = dig;
        chk("bp_digest", held, DIG_ABC);
        v1 = 1'b1;
        blk1 = BLK_EMPTY;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_out_valid_held", 256'(ov1), 256'(1));
            chk("bp_in_ready_low", 256'(rdy1), 256'(0));
            chk("bp_digest_stable", dig1, held);
        end
        ordy1 = 1'b1;
        step();
        hs = cyc;
        chk("bp_handshake_valid", 256'(ov1), 256'(0));
        run(1'b0, BLK_EMPTY, acc, ov_at, dig);
        chk("bp_accept_after_handshake", 256'(acc - hs), 256'(1));
        chk("bp_second_digest", dig, DIG_EMPTY);
        step();

        // Reset in the middle of an "abc" block
        v1 = 1'b1;
        blk1 = BLK_ABC;
        pre_i = 0;
        for (int i = 0; i < 20 && pre_i == 0; i++) begin
            pre = rdy1;
            step();
            if (pre) pre_i = 1;
        end
        v1 = 1'b0;
        chk("midrst_accepted", 256'(pre_i), 256'(1));
        repeat (30) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 256'(ov1), 256'(0));
        chk("midrst_digest", dig1, '0);
        chk("midrst_in_ready", 256'(rdy1), 256'(1));
        step();
        step();
        rst_n = 1'b1;
        step();
        run(1'b0, BLK_ABC, acc, ov_at, dig);
        chk("midrst_abc_digest", dig, DIG_ABC);
        step();

        // Back-to-back: three "abc" blocks, in_valid and out_ready held high
        v1 = 1'b1;
        blk1 = BLK_ABC;
        n_acc = 0;
        n_dig = 0;
        accs = '{default: -1000};
        digs = '{default: '0};
        for (int i = 0; i < 300 && n_dig < 3; i++) begin
            pre = rdy1;
            step();
            if (pre && n_acc < 3) begin
                accs[n_acc] = cyc;
                n_acc++;
                if (n_acc == 3) v1 = 1'b0;
            end
            if (ov1 && n_dig < 3) begin
                digs[n_dig] = dig1;
                n_dig++;
            end
        end
        v1 = 1'b0;
        chk("b2b_accept_count", 256'(n_acc), 256'(3));
        chk("b2b_digest_count", 256'(n_dig), 256'(3));
        chk("b2b_digest0", digs[0], DIG_ABC);
        chk("b2b_digest1", digs[1], DIG_ABC);
        chk("b2b_digest2", digs[2], DIG_ABC);
        // 64 rounds + FINAL + DONE + IDLE between accept edges
        chk("b2b_spacing01", 256'(accs[1] - accs[0]), 256'(67));
        chk("b2b_spacing12", 256'(accs[2] - accs[1]), 256'(67));
        step();

        // Four rounds per clock
        run(1'b1, BLK_EMPTY, acc, ov_at, dig);
        chk("r4_empty_latency", 256'(ov_at - acc), 256'(17));
        chk("r4_empty_digest", dig, DIG_EMPTY);
        step();
        run(1'b1, BLK_ABC, acc, ov_at, dig);
        chk("r4_abc_latency", 256'(ov_at - acc), 256'(17));
        chk("r4_abc_digest", dig, DIG_ABC);
        step();

`ifdef SHA256_CHAIN_EN
        // Two-block message, then a fresh single block restarts from IV
        fb1 = 1'b1;
        run(1'b0, BLK_TWO_1, acc, ov_at, dig);
        step();
        fb1 = 1'b0;
        run(1'b0, BLK_TWO_2, acc, ov_at, dig);
        chk("chain_two_block_digest", dig, DIG_TWO);
        step();
        fb1 = 1'b1;
        run(1'b0, BLK_ABC, acc, ov_at, dig);
        chk("chain_restart_abc", dig, DIG_ABC);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
